if_fetch_unit: RTL

Dual-issue instruction fetch front end. Owns the program counter, drives the word address into the synchronous two-wide instruction ROM, and absorbs its one-cycle read latency in a 2-entry pair buffer. It presents {pc, instr1, instr2} to decode through a valid/ready handshake. It sits directly upstream of the ROM and directly upstream of decode, and accepts PC redirects from execute.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_pair_fifo.sv | 44 ++++
 rtl/if_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the dual-issue instruction fetch front end.
package if_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          FIFO_DEPTH = 2;
    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        v2;
    } fetch_pair_t;

    // Value decode sees whenever nothing is buffered.
    localparam fetch_pair_t IDLE_PAIR = '{pc: 32'h0, i1: NOP_INSTR, i2: NOP_INSTR, v2: 1'b0};

endpackage

// File: rtl/if_pair_fifo.sv
// Two-entry buffer of fetched instruction pairs; the head reads as IDLE_PAIR when empty.
module if_pair_fifo
    import if_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_pair_t      push_data,
    output fetch_pair_t      head,
    output logic [CNT_W-1:0] count
);

    fetch_pair_t mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : IDLE_PAIR;

endmodule

// File: rtl/if_fetch_unit.sv
// Dual-issue fetch front end: PC, credit-gated ROM issue, redirect flush, pair buffer.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr1,
    output logic [31:0]       if_instr2,
    output logic              if_instr2_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_redirects
`endif
);

    logic [31:0]      pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic             inflight_last;
    logic [CNT_W-1:0] fifo_count;
    fetch_pair_t      head;
    fetch_pair_t      push_data;
    logic             push;
    logic             pop;
    logic             issue;
    logic             last_word;
    logic [2:0]       occupancy;
    logic [2:0]       credit;
    logic [31:0]      redirect_target;

    assign rom_addr        = pc[ROM_AW+1:2];
    assign last_word       = &rom_addr;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign if_valid        = (fifo_count != '0);
    assign if_pc           = head.pc;
    assign if_instr1       = head.i1;
    assign if_instr2       = head.i2;
    assign if_instr2_valid = head.v2;

    // A redirect cancels this cycle's pop, push and issue outright.
    assign pop       = if_valid && if_ready && !redirect_valid;
    assign push      = inflight && !redirect_valid;
    assign occupancy = {{(3-CNT_W){1'b0}}, fifo_count} + {2'b00, inflight};
    assign credit    = 3'd1 + {2'b00, pop};
    assign issue     = !redirect_valid && (occupancy <= credit);

    always_comb begin
        push_data    = IDLE_PAIR;
        push_data.pc = inflight_pc;
        push_data.i1 = rom_instr1;
        push_data.i2 = inflight_last ? NOP_INSTR : rom_instr2;
        push_data.v2 = !inflight_last;
    end

    // The last ROM word has no partner, so it issues alone and the PC steps by 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_last <= 1'b0;
        end else if (redirect_valid) begin
            pc            <= redirect_target;
            inflight      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc   <= pc;
                inflight_last <= last_word;
                pc            <= pc + (last_word ? 32'd4 : 32'd8);
            end
        end
    end

    if_pair_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head      (head),
        .count     (fifo_count)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (if_valid && !if_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
